// File: rtl/uart_ram_loader.sv
// ---------------------------------------------------------------------------
// uart_ram_loader
//
// Serial program loader for the 4096x16 main RAM. A host streams bytes over
// UART: a big-endian 16-bit word count N, then N big-endian data words. Each
// assembled word is written to RAM sequentially from address 0. The top level
// holds the CPU in reset while busy is high.
//
// Optional feature (macro CHECKSUM_EN): after the Nth word the host sends one
// byte equal to the XOR of all 2N data bytes; a mismatch sets chk_err. When
// the macro is undefined there is no checksum byte and chk_err is tied to 0.
//
// Ports:
//   clk        free-running board clock
//   reset      synchronous, active-low reset
//   rx         UART serial input (idle high, asynchronous to clk)
//   load_en    level; high arms the loader, low returns it to IDLE
//   w_en       one-cycle RAM write strobe
//   addr       RAM write address (wraps modulo 2**ADDR_WIDTH)
//   w_data     RAM write data, holds its last value between strobes
//   busy       high while a load is in progress
//   done       high after N words written, until load_en drops
//   frame_err  sticky; a stop bit was sampled low during a load
//   chk_err    sticky; checksum mismatch
//   word_count words written in the current load
// ---------------------------------------------------------------------------
module uart_ram_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  load_en,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err,
    output logic                  chk_err,
    output logic [15:0]           word_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    // -----------------------------------------------------------------------
    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    // All flops reset to the idle-line level so reset never looks like a start.
    // -----------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // -----------------------------------------------------------------------
    // UART receiver. The start bit is re-checked half a bit after the edge so
    // short low glitches are dropped; every later sample is one bit apart and
    // therefore lands near the middle of each bit.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       rx_byte, rx_byte_n;
    logic             byte_valid, byte_valid_n;
    logic             rx_ferr, rx_ferr_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            bit_idx    <= bit_idx_n;
            rx_byte    <= rx_byte_n;
            byte_valid <= byte_valid_n;
            rx_ferr    <= rx_ferr_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt;
        bit_idx_n    = bit_idx;
        rx_byte_n    = rx_byte;
        byte_valid_n = 1'b0;
        rx_ferr_n    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n   = '0;
                    bit_idx_n  = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_n  = '0;
                    rx_byte_n = {rx_sync, rx_byte[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_n     = '0;
                    rx_state_n   = RX_IDLE;
                    byte_valid_n = rx_sync;
                    rx_ferr_n    = !rx_sync;
                end else begin
                    rx_cnt_n = rx_cnt + 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Loader FSM. The write strobe is scheduled on the low byte and issued the
    // following cycle; the FSM stays in DAT_LO for that strobe cycle and only
    // then decides whether the load is complete.
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO,
`ifdef CHECKSUM_EN
        CHK,
`endif
        DONE, ERR
    } state_t;

    state_t                state, state_n;
    logic [7:0]            hi_byte, hi_byte_n;
    logic [15:0]           n_words, n_words_n;
    logic [7:0]            checksum, checksum_n;
    logic                  w_en_n, busy_n, done_n, frame_err_n, chk_err_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] w_data_n;
    logic [15:0]           word_count_n;
    logic                  in_load;
    state_t                after_last;

`ifdef CHECKSUM_EN
    assign after_last = CHK;
`else
    assign after_last = DONE;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            hi_byte    <= '0;
            n_words    <= '0;
            checksum   <= '0;
            w_en       <= 1'b0;
            addr       <= '0;
            w_data     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            chk_err    <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_n;
            hi_byte    <= hi_byte_n;
            n_words    <= n_words_n;
            checksum   <= checksum_n;
            w_en       <= w_en_n;
            addr       <= addr_n;
            w_data     <= w_data_n;
            busy       <= busy_n;
            done       <= done_n;
            frame_err  <= frame_err_n;
            chk_err    <= chk_err_n;
            word_count <= word_count_n;
        end
    end

    always_comb begin
        state_n      = state;
        hi_byte_n    = hi_byte;
        n_words_n    = n_words;
        checksum_n   = checksum;
        w_en_n       = 1'b0;
        addr_n       = addr;
        w_data_n     = w_data;
        frame_err_n  = frame_err;
        chk_err_n    = chk_err;
        word_count_n = word_count;
        in_load      = (state == HDR_HI) || (state == HDR_LO) ||
                       (state == DAT_HI) || (state == DAT_LO);
`ifdef CHECKSUM_EN
        in_load      = in_load || (state == CHK);
`endif

        // A strobe on the bus is a completed write, so it is always counted,
        // even if load_en drops in that same cycle.
        if (w_en) begin
            addr_n       = addr + 1'b1;
            word_count_n = word_count + 16'd1;
        end

        case (state)
            IDLE: begin
                if (load_en) begin
                    state_n      = HDR_HI;
                    frame_err_n  = 1'b0;
                    chk_err_n    = 1'b0;
                    word_count_n = '0;
                    addr_n       = '0;
                    checksum_n   = '0;
                end
            end
            HDR_HI: begin
                if (byte_valid) begin
                    n_words_n[15:8] = rx_byte;
                    state_n         = HDR_LO;
                end
            end
            HDR_LO: begin
                if (byte_valid) begin
                    n_words_n[7:0] = rx_byte;
                    state_n        = ({n_words[15:8], rx_byte} == 16'd0) ? DONE : DAT_HI;
                end
            end
            DAT_HI: begin
                if (byte_valid) begin
                    hi_byte_n  = rx_byte;
                    checksum_n = checksum ^ rx_byte;
                    state_n    = DAT_LO;
                end
            end
            DAT_LO: begin
                if (byte_valid) begin
                    w_data_n   = DATA_WIDTH'({hi_byte, rx_byte});
                    w_en_n     = 1'b1;
                    checksum_n = checksum ^ rx_byte;
                end else if (w_en) begin
                    state_n = (word_count + 16'd1 == n_words) ? after_last : DAT_HI;
                end
            end
`ifdef CHECKSUM_EN
            CHK: begin
                if (byte_valid) begin
                    chk_err_n = (rx_byte != checksum);
                    state_n   = DONE;
                end
            end
`endif
            DONE, ERR: begin
                if (!load_en) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort and frame-error handling override the per-state decisions,
        // cancelling any strobe scheduled in this cycle.
        if (in_load) begin
            if (!load_en) begin
                state_n  = IDLE;
                w_en_n   = 1'b0;
                w_data_n = w_data;
            end else if (rx_ferr) begin
                state_n     = ERR;
                frame_err_n = 1'b1;
                w_en_n      = 1'b0;
                w_data_n    = w_data;
            end
        end

        busy_n = (state_n != IDLE) && (state_n != DONE) && (state_n != ERR);
        done_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_ram_loader
//
// Directed bench for uart_ram_loader with a short bit period (4 clocks) and a
// 4-bit address so the address wrap is reachable quickly. Every RAM strobe is
// logged and compared against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_uart_ram_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          load_en = 1'b0;
    logic          w_en;
    logic [AW-1:0] addr;
    logic [15:0]   w_data;
    logic          busy, done, frame_err, chk_err;
    logic [15:0]   word_count;

    int tests_run = 0;
    int tests_failed = 0;
    int base;

    logic [AW-1:0] wr_addr_q[$];
    logic [15:0]   wr_data_q[$];
    logic [15:0]   tx_words[$];

    uart_ram_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .load_en   (load_en),
        .w_en      (w_en),
        .addr      (addr),
        .w_data    (w_data),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .chk_err   (chk_err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Log every RAM write seen on the bus.
    always @(negedge clk) begin
        if (w_en) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(w_data);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Sends one UART frame, LSB first, then a short idle gap.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends tx_words big-endian, followed by the XOR checksum when enabled.
    task automatic send_words();
        logic [7:0] sum;
        sum = 8'h00;
        foreach (tx_words[i]) begin
            send_byte(tx_words[i][15:8], 1'b1);
            send_byte(tx_words[i][7:0], 1'b1);
            sum = sum ^ tx_words[i][15:8] ^ tx_words[i][7:0];
        end
`ifdef CHECKSUM_EN
        send_byte(sum, 1'b1);
`endif
    endtask

    task automatic send_load(input logic [15:0] n);
        send_byte(n[15:8], 1'b1);
        send_byte(n[7:0], 1'b1);
        if (n != 16'd0) begin
            send_words();
        end
    endtask

    task automatic rearm();
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        load_en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_w_en", 32'(w_en), 32'd0);
        check_output("rst_addr", 32'(addr), 32'd0);
        check_output("rst_w_data", 32'(w_data), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_frame_err", 32'(frame_err), 32'd0);
        check_output("rst_chk_err", 32'(chk_err), 32'd0);
        check_output("rst_word_count", 32'(word_count), 32'd0);

        reset = 1'b1;
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        check_output("arm_busy", 32'(busy), 32'd1);

        // Three-word load
        tx_words = '{16'h1234, 16'hABCD, 16'h0007};
        base = wr_data_q.size();
        send_load(16'd3);
        repeat (10) @(negedge clk);
        check_output("t1_num_writes", 32'(wr_data_q.size() - base), 32'd3);
        if (wr_data_q.size() - base == 3) begin
            check_output("t1_addr0", 32'(wr_addr_q[base]), 32'd0);
            check_output("t1_data0", 32'(wr_data_q[base]), 32'h1234);
            check_output("t1_addr1", 32'(wr_addr_q[base+1]), 32'd1);
            check_output("t1_data1", 32'(wr_data_q[base+1]), 32'hABCD);
            check_output("t1_addr2", 32'(wr_addr_q[base+2]), 32'd2);
            check_output("t1_data2", 32'(wr_data_q[base+2]), 32'h0007);
        end
        check_output("t1_word_count", 32'(word_count), 32'd3);
        check_output("t1_done", 32'(done), 32'd1);
        check_output("t1_busy", 32'(busy), 32'd0);
        check_output("t1_addr_out", 32'(addr), 32'd3);
        check_output("t1_w_data_hold", 32'(w_data), 32'h0007);

        // Bytes in DONE are ignored
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        repeat (10) @(negedge clk);
        check_output("done_ignore_writes", 32'(wr_data_q.size() - base), 32'd3);
        check_output("done_ignore_done", 32'(done), 32'd1);

        // Dropping load_en clears done but keeps word_count until re-arm
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        check_output("drop_done", 32'(done), 32'd0);
        check_output("drop_word_count", 32'(word_count), 32'd3);
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rearm_word_count", 32'(word_count), 32'd0);
        check_output("rearm_busy", 32'(busy), 32'd1);
        check_output("rearm_addr", 32'(addr), 32'd0);

        // Zero-length load
        tx_words.delete();
        base = wr_data_q.size();
        send_load(16'd0);
        repeat (10) @(negedge clk);
        check_output("n0_done", 32'(done), 32'd1);
        check_output("n0_busy", 32'(busy), 32'd0);
        check_output("n0_writes", 32'(wr_data_q.size() - base), 32'd0);

        // 17 words into a 16-entry address space: word 16 wraps to address 0
        rearm();
        tx_words.delete();
        for (int i = 0; i < 17; i++) begin
            tx_words.push_back(16'hA000 + 16'(i));
        end
        base = wr_data_q.size();
        send_load(16'd17);
        repeat (10) @(negedge clk);
        check_output("wrap_writes", 32'(wr_data_q.size() - base), 32'd17);
        if (wr_data_q.size() - base == 17) begin
            check_output("wrap_addr15", 32'(wr_addr_q[base+15]), 32'd15);
            check_output("wrap_addr16", 32'(wr_addr_q[base+16]), 32'd0);
            check_output("wrap_data16", 32'(wr_data_q[base+16]), 32'hA010);
        end
        check_output("wrap_word_count", 32'(word_count), 32'd17);
        check_output("wrap_addr_out", 32'(addr), 32'd1);
        check_output("wrap_done", 32'(done), 32'd1);

        // Frame error on the low byte of the second word
        rearm();
        base = wr_data_q.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b0);
        repeat (10) @(negedge clk);
        check_output("ferr_flag", 32'(frame_err), 32'd1);
        check_output("ferr_busy", 32'(busy), 32'd0);
        check_output("ferr_done", 32'(done), 32'd0);
        check_output("ferr_writes", 32'(wr_data_q.size() - base), 32'd1);
        check_output("ferr_word_count", 32'(word_count), 32'd1);
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        check_output("ferr_sticky", 32'(frame_err), 32'd1);
        load_en = 1'b1;
        repeat (3) @(negedge clk);
        check_output("ferr_cleared", 32'(frame_err), 32'd0);
        check_output("ferr_rearm_busy", 32'(busy), 32'd1);

        // One-cycle rx glitch while waiting for a data high byte
        base = wr_data_q.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        check_output("glitch_busy", 32'(busy), 32'd1);
        check_output("glitch_writes", 32'(wr_data_q.size() - base), 32'd0);
        check_output("glitch_frame_err", 32'(frame_err), 32'd0);
        tx_words = '{16'h9ABC};
        send_words();
        repeat (10) @(negedge clk);
        check_output("glitch_after_writes", 32'(wr_data_q.size() - base), 32'd1);
        if (wr_data_q.size() - base == 1) begin
            check_output("glitch_after_addr", 32'(wr_addr_q[base]), 32'd0);
            check_output("glitch_after_data", 32'(wr_data_q[base]), 32'h9ABC);
        end
        check_output("glitch_after_done", 32'(done), 32'd1);

`ifdef CHECKSUM_EN
        // Correct checksum: 12 ^ 34 = 26
        rearm();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h26, 1'b1);
        repeat (10) @(negedge clk);
        check_output("chk_good_err", 32'(chk_err), 32'd0);
        check_output("chk_good_done", 32'(done), 32'd1);

        // Wrong checksum
        rearm();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h27, 1'b1);
        repeat (10) @(negedge clk);
        check_output("chk_bad_err", 32'(chk_err), 32'd1);
        check_output("chk_bad_done", 32'(done), 32'd1);
`else
        check_output("chk_err_tied", 32'(chk_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
